// File: rtl/ss_division_run_ctrl_pkg.sv
// rtl/ss_division_run_ctrl_pkg.sv - shared types and constants for the stochastic divider run controller
package ss_division_run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int OP_W  = 9;
    localparam int RN_W  = 8;
    localparam int CNT_W = 11;
    localparam int LEN_W = 4;
    localparam int CYC_W = 10;

    localparam int LEN_MIN_DEF = 3;
    localparam int LEN_MAX_DEF = 9;

    localparam logic [RN_W-1:0] SEED_X   = 8'hA5;
    localparam logic [RN_W-1:0] SEED_Y   = 8'h5A;
    localparam logic [RN_W-1:0] SEED_Z   = 8'hC3;
    // Taps 8,6,5,4 counted from 1 at the LSB end map onto bits 7,5,4,3.
    localparam logic [RN_W-1:0] TAP_MASK = 8'hB8;

    function automatic logic [RN_W-1:0] lfsr_step(input logic [RN_W-1:0] s);
        return {s[RN_W-2:0], ^(s & TAP_MASK)};
    endfunction

endpackage

// File: rtl/ss_lfsr8.sv
// rtl/ss_lfsr8.sv - 8-bit Fibonacci LFSR with enable and synchronous reseed
module ss_lfsr8
    import ss_division_run_ctrl_pkg::*;
#(
    parameter logic [RN_W-1:0] SEED = SEED_X
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            reseed_i,
    output logic [RN_W-1:0] q_o
);

    logic [RN_W-1:0] lfsr_q;
    logic [RN_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (reseed_i) begin
            lfsr_d = SEED;
        end else if (en_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q_o = lfsr_q;

endmodule

// File: rtl/ss_division_run_ctrl.sv
// rtl/ss_division_run_ctrl.sv - sequences load, stream window, drain and result capture for the divider
module ss_division_run_ctrl
    import ss_division_run_ctrl_pkg::*;
#(
    parameter int DRAIN_CYC = 1,
    parameter int LEN_MIN   = LEN_MIN_DEF,
    parameter int LEN_MAX   = LEN_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  x_in,
    input  logic [OP_W-1:0]  y_in,
    input  logic [LEN_W-1:0] len_sel,
    input  logic             cancel,
    output logic             dp_rst_n,
    output logic [OP_W-1:0]  dp_x_input,
    output logic [OP_W-1:0]  dp_y_input,
    output logic [RN_W-1:0]  dp_x_randnum,
    output logic [RN_W-1:0]  dp_y_randnum,
    output logic [RN_W-1:0]  dp_z_randnum,
    input  logic [CNT_W-1:0] dp_counter,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] result,
    output logic [LEN_W-1:0] result_len,
    output logic             busy
);

    localparam logic [CYC_W-1:0] DRAIN_LAST = (DRAIN_CYC > 0) ? CYC_W'(DRAIN_CYC - 1) : '0;
    localparam state_t           AFTER_RUN  = (DRAIN_CYC > 0) ? ST_DRAIN : ST_DONE;

    state_t           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [OP_W-1:0]  x_q, x_d;
    logic [OP_W-1:0]  y_q, y_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic [LEN_W-1:0] result_len_q, result_len_d;
    logic             dp_rst_n_q;
    logic [LEN_W-1:0] len_eff;
    logic [CYC_W-1:0] run_last;
    logic             lfsr_en;
    logic             lfsr_reseed;

    always_comb begin
        len_eff = len_sel;
        if (int'(len_sel) < LEN_MIN) begin
            len_eff = LEN_W'(LEN_MIN);
        end else if (int'(len_sel) > LEN_MAX) begin
            len_eff = LEN_W'(LEN_MAX);
        end
    end

    assign run_last = CYC_W'((32'd1 << len_q) - 32'd1);

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        len_d        = len_q;
        x_d          = x_q;
        y_d          = y_q;
        result_d     = result_q;
        result_len_d = result_len_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d     = x_in;
                    y_d     = y_in;
                    len_d   = len_eff;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cyc_d   = '0;
                state_d = cancel ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (cyc_q == run_last) begin
                    cyc_d   = '0;
                    state_d = AFTER_RUN;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (cyc_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Capture only on the edge that enters DONE so the result stays frozen while waiting.
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            result_d     = dp_counter;
            result_len_d = len_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cyc_q        <= '0;
            len_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            result_q     <= '0;
            result_len_q <= '0;
            dp_rst_n_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            len_q        <= len_d;
            x_q          <= x_d;
            y_q          <= y_d;
            result_q     <= result_d;
            result_len_q <= result_len_d;
            dp_rst_n_q   <= (state_d != ST_LOAD);
        end
    end

    assign lfsr_en     = (state_q == ST_RUN) && !cancel;
    assign lfsr_reseed = (state_q == ST_LOAD) && !cancel;

    ss_lfsr8 #(.SEED(SEED_X)) u_lfsr_x (
        .clk_i   (clk),
        .rst_ni  (rst),
        .en_i    (lfsr_en),
        .reseed_i(lfsr_reseed),
        .q_o     (dp_x_randnum)
    );

    ss_lfsr8 #(.SEED(SEED_Y)) u_lfsr_y (
        .clk_i   (clk),
        .rst_ni  (rst),
        .en_i    (lfsr_en),
        .reseed_i(lfsr_reseed),
        .q_o     (dp_y_randnum)
    );

    ss_lfsr8 #(.SEED(SEED_Z)) u_lfsr_z (
        .clk_i   (clk),
        .rst_ni  (rst),
        .en_i    (lfsr_en),
        .reseed_i(lfsr_reseed),
        .q_o     (dp_z_randnum)
    );

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign dp_rst_n   = dp_rst_n_q;
    assign dp_x_input = x_q;
    assign dp_y_input = y_q;
    assign result     = result_q;
    assign result_len = result_len_q;

endmodule

// File: tb/tb_ss_division_run_ctrl.sv
// tb/tb_ss_division_run_ctrl.sv - directed self-checking bench for ss_division_run_ctrl
module tb_ss_division_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  x_in;
    logic [8:0]  y_in;
    logic [3:0]  len_sel;
    logic        cancel;
    logic        dp_rst_n;
    logic [8:0]  dp_x_input;
    logic [8:0]  dp_y_input;
    logic [7:0]  dp_x_randnum;
    logic [7:0]  dp_y_randnum;
    logic [7:0]  dp_z_randnum;
    logic [10:0] dp_counter;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] result;
    logic [3:0]  result_len;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int edges       = 0;

    logic [7:0]  seq_x [4];
    logic [7:0]  seq_y [4];
    logic [7:0]  seq_z [4];
    logic [7:0]  hold_x, hold_y, hold_z;
    logic [10:0] hold_res;

    always #5 clk = ~clk;

    // Divider stand-in: counts cycles since the datapath clear was released.
    always @(posedge clk) begin
        if (!dp_rst_n) dp_counter <= '0;
        else           dp_counter <= dp_counter + 11'd1;
    end

    ss_division_run_ctrl #(.DRAIN_CYC(1), .LEN_MIN(3), .LEN_MAX(9)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x_in        (x_in),
        .y_in        (y_in),
        .len_sel     (len_sel),
        .cancel      (cancel),
        .dp_rst_n    (dp_rst_n),
        .dp_x_input  (dp_x_input),
        .dp_y_input  (dp_y_input),
        .dp_x_randnum(dp_x_randnum),
        .dp_y_randnum(dp_y_randnum),
        .dp_z_randnum(dp_z_randnum),
        .dp_counter  (dp_counter),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_len  (result_len),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic handshake(input logic [8:0] x, input logic [8:0] y, input logic [3:0] l);
        x_in     = x;
        y_in     = y;
        len_sel  = l;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        edges    = 0;
    endtask

    task automatic wait_valid(input int bound);
        for (int i = 0; i < bound && out_valid !== 1'b1; i++) step();
    endtask

    task automatic finish_done();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ack_out_valid", 32'(out_valid), 32'd0);
        chk("ack_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; x_in = '0; y_in = '0; len_sel = '0;
        cancel = 1'b0; out_ready = 1'b0;
        step(); step();
        chk("rst_dp_rst_n", 32'(dp_rst_n), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_result_len", 32'(result_len), 32'd0);
        chk("rst_x_input", 32'(dp_x_input), 32'd0);
        chk("rst_rn", {8'd0, dp_x_randnum, dp_y_randnum, dp_z_randnum}, 32'h00A55AC3);
        rst = 1'b1;
        step();
        chk("rel_dp_rst_n", 32'(dp_rst_n), 32'd1);

        // Op A: full-length run, LFSR sequence capture
        handshake(9'd128, 9'd256, 4'd9);
        chk("a_load_dp_rst_n", 32'(dp_rst_n), 32'd0);
        chk("a_load_busy", 32'(busy), 32'd1);
        chk("a_load_in_ready", 32'(in_ready), 32'd0);
        chk("a_operands", {7'd0, dp_x_input, 7'd0, dp_y_input}, {16'd128, 16'd256});
        for (int i = 0; i < 4; i++) begin
            step();
            seq_x[i] = dp_x_randnum; seq_y[i] = dp_y_randnum; seq_z[i] = dp_z_randnum;
        end
        chk("a_run_dp_rst_n", 32'(dp_rst_n), 32'd1);
        chk("a_rn0", {8'd0, seq_x[0], seq_y[0], seq_z[0]}, 32'h00A55AC3);
        chk("a_rn1", {8'd0, seq_x[1], seq_y[1], seq_z[1]}, 32'h004AB487);
        wait_valid(600);
        chk("a_out_valid", 32'(out_valid), 32'd1);
        chk("a_latency", 32'(edges), 32'd514);
        chk("a_result", 32'(result), 32'd512);
        chk("a_result_len", 32'(result_len), 32'd9);

        // DONE holds for 20 cycles with in_valid pulses ignored
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            step();
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_result", 32'(result), 32'd512);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        finish_done();

        // Op B: len below minimum, cancel alongside request in IDLE
        cancel = 1'b1;
        handshake(9'd5, 9'd7, 4'd0);
        cancel = 1'b0;
        chk("b_accepted", 32'(busy), 32'd1);
        chk("b_operands", {7'd0, dp_x_input, 7'd0, dp_y_input}, {16'd5, 16'd7});
        for (int i = 0; i < 4; i++) begin
            step();
            chk("b_rn_repeat", {8'd0, dp_x_randnum, dp_y_randnum, dp_z_randnum},
                {8'd0, seq_x[i], seq_y[i], seq_z[i]});
        end
        wait_valid(100);
        chk("b_latency", 32'(edges), 32'd10);
        chk("b_result", 32'(result), 32'd8);
        chk("b_result_len", 32'(result_len), 32'd3);
        finish_done();

        // Op C: cancel at RUN cycle 100
        handshake(9'd33, 9'd44, 4'd15);
        while (edges < 100) step();
        cancel = 1'b1;
        hold_x = dp_x_randnum; hold_y = dp_y_randnum; hold_z = dp_z_randnum;
        step();
        cancel = 1'b0;
        chk("c_in_ready", 32'(in_ready), 32'd1);
        chk("c_busy", 32'(busy), 32'd0);
        chk("c_rn_hold", {8'd0, dp_x_randnum, dp_y_randnum, dp_z_randnum},
            {8'd0, hold_x, hold_y, hold_z});
        for (int i = 0; i < 5; i++) begin
            step();
            chk("c_no_valid", 32'(out_valid), 32'd0);
        end
        chk("c_result_kept", {result_len, result}, {4'd3, 11'd8});
        chk("c_operands_kept", 32'(dp_x_input), 32'd33);

        // Op D: len above maximum, completes normally after cancel
        handshake(9'd300, 9'd301, 4'd15);
        wait_valid(600);
        chk("d_latency", 32'(edges), 32'd514);
        chk("d_result", 32'(result), 32'd512);
        chk("d_result_len", 32'(result_len), 32'd9);
        hold_res = result;
        finish_done();
        chk("d_result_after_ack", 32'(result), 32'(hold_res));

        // Reset mid-RUN
        handshake(9'd10, 9'd20, 4'd9);
        while (edges < 50) step();
        rst = 1'b0;
        step();
        chk("mr_dp_rst_n", 32'(dp_rst_n), 32'd0);
        chk("mr_state", {29'd0, in_ready, busy, out_valid}, {29'd0, 3'b100});
        chk("mr_result", {result_len, result}, 32'd0);
        chk("mr_operands", {7'd0, dp_x_input, 7'd0, dp_y_input}, 32'd0);
        chk("mr_rn", {8'd0, dp_x_randnum, dp_y_randnum, dp_z_randnum}, 32'h00A55AC3);
        rst = 1'b1;
        step();
        chk("mr_rel_dp_rst_n", 32'(dp_rst_n), 32'd1);
        handshake(9'd1, 9'd2, 4'd4);
        wait_valid(100);
        chk("e_latency", 32'(edges), 32'd18);
        chk("e_result", 32'(result), 32'd16);
        chk("e_result_len", 32'(result_len), 32'd4);
        finish_done();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ss_division_run_ctrl.md
SS_DIVISION_RUN_CTRL -- requirements
Module: ss_division_run_ctrl

Interface
REQ-001 Parameter DRAIN_CYC, default 1: extra cycles after the stream window, covering divider latency before capture.
REQ-002 Parameter LEN_MIN, default 3; LEN_MAX, default 9: legal log2 stream-length range.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  operand request.
REQ-006 in_ready  output  1  controller idle, accepts operands.
REQ-007 x_in  input  9  dividend magnitude for the generator.
REQ-008 y_in  input  9  divisor magnitude.
REQ-009 len_sel  input  4  log2 of stream length, sampled at handshake.
REQ-010 cancel  input  1  abort current operation.
REQ-011 dp_rst_n  output  1  registered active-low clear to the divider datapath.
REQ-012 dp_x_input, dp_y_input  output  9 each  latched operands.
REQ-013 dp_x_randnum, dp_y_randnum, dp_z_randnum  output  8 each  LFSR values.
REQ-014 dp_counter  input  11  datapath accumulated z stream count.
REQ-015 out_valid  output  1  result available.
REQ-016 out_ready  input  1  consumer accepts result.
REQ-017 result  output  11  captured dp_counter.
REQ-018 result_len  output  4  effective len_sel used for result.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 States: IDLE, LOAD, RUN, DRAIN, DONE; 3-bit encoding.
REQ-021 in_ready SHALL equal (state==IDLE).
REQ-022 IDLE: in_valid=1 latches x_in, y_in and the clamped len_sel, then goes to LOAD; in_valid=0 stays in IDLE.
REQ-023 len_sel clamping: below LEN_MIN uses LEN_MIN; above LEN_MAX uses LEN_MAX.
REQ-024 LOAD lasts exactly 1 cycle: dp_rst_n=0, all three LFSRs reseeded; next state RUN.
REQ-025 dp_rst_n SHALL be 1 in every state except LOAD; it is a flop output and must not be decoded combinationally.
REQ-026 RUN lasts exactly 2^len cycles, counted by a 10-bit cycle counter cleared in LOAD; the final RUN cycle goes to DRAIN.
REQ-027 LFSRs advance one step per cycle in RUN only; they hold their values in IDLE, DRAIN and DONE.
REQ-028 Each LFSR is 8-bit Fibonacci, taps 8,6,5,4. Seeds: x 8'hA5, y 8'h5A, z 8'hC3.
REQ-029 DRAIN lasts DRAIN_CYC cycles; with DRAIN_CYC=0 the FSM goes RUN to DONE directly.
REQ-030 On entry to DONE: result <= dp_counter and result_len <= effective len; out_valid=1.
REQ-031 DONE holds result and out_valid stable until out_ready=1; the handshake cycle returns to IDLE with out_valid=0 on the next cycle.
REQ-032 in_valid is ignored outside IDLE; back-to-back operation costs at least one IDLE cycle.
REQ-033 cancel=1 in LOAD, RUN or DRAIN: go to IDLE next cycle, no result, result unchanged; LFSRs hold.
REQ-034 cancel is ignored in IDLE and DONE; a pending result cannot be discarded by cancel.
REQ-035 cancel and in_valid in the same IDLE cycle: the request is accepted.
REQ-036 dp_x_input and dp_y_input hold the latched operands from acceptance until the next acceptance.

Reset
REQ-037 rst=0 at a clock edge, regardless of state: state IDLE, in_ready=1 after release, out_valid=0, busy=0, result=0, result_len=0, cycle counter 0.
REQ-038 Reset values: dp_rst_n=0 while rst=0, 1 after; operand registers 0; LFSRs at their seeds.
REQ-039 Reset mid-RUN discards the operation; the first post-reset handshake behaves as from power-up.

Structure
REQ-040 Shared package holds: state encoding, LFSR seeds, tap mask, LEN_MIN/LEN_MAX defaults, width constants 9/8/11.
REQ-041 One sub-module ss_lfsr8 (enable, reseed, seed parameter); instantiated three times.
REQ-042 Target 150-300 lines of RTL; no combinational path from in_valid or out_ready to any datapath output.

Verification
REQ-043 x_in=128, y_in=256, len_sel=9, DRAIN_CYC=1 with divider model -> LOAD 1 cycle, RUN 512 cycles, DRAIN 1 cycle; out_valid rises on cycle 515 after handshake; result equals dp_counter at that edge.
REQ-044 len_sel=0, then len_sel=15 -> RUN lasts 8 cycles (result_len=3), then 512 cycles (result_len=9).
REQ-045 First RUN after reset -> randnum sequence starts A5/5A/C3; identical across two consecutive operations, confirming reseed.
REQ-046 cancel asserted at RUN cycle 100 -> IDLE next cycle, out_valid never asserted, result unchanged; next request completes normally.
REQ-047 out_ready held low 20 cycles in DONE -> result and out_valid stable; in_valid pulses ignored; IDLE one cycle after out_ready=1.
REQ-048 rst=0 for 1 cycle mid-RUN -> all outputs at reset values next cycle; dp_rst_n=0 during reset.
